credit_buffer: RTL

Receiver-side input buffer for one NoC link: stores flits arriving from the upstream router and returns one credit per flit consumed. It is the downstream partner of the sender's credit counter, which starts at 5 credits, decrements on each sent flit and increments on each returned credit pulse. DEPTH must equal the sender's reset credit count, so a well-behaved sender can never overflow this buffer.

---
 rtl/credit_buffer.sv | 104 ++++++++++
 1 files changed

// File: rtl/credit_buffer.sv
// credit_buffer
//   Receiver-side flit buffer for one NoC link. Flits pushed by the upstream
//   router are held in a circular array. Each flit taken by the local consumer
//   returns one credit pulse to the upstream credit counter. DEPTH matches the
//   sender's reset credit count, so a compliant sender never overflows it.
//
// Ports
//   clk           : clock, all state updates on the rising edge
//   reset         : asynchronous active-low reset
//   flit_valid_i  : upstream flit present (push request)
//   flit_data_i   : upstream flit payload
//   pop_i         : consumer takes the head flit this cycle
//   flit_valid_o  : buffer non-empty
//   flit_data_o   : head flit (show-ahead), 0 when empty
//   cc_inc_o      : one-cycle credit-return pulse per consumed flit
//   count_o       : current occupancy, 0..DEPTH
//   overflow_o    : sticky flag, a push was dropped because the buffer was full
module credit_buffer #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 5,
    localparam int PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W     = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flit_valid_i,
    input  logic [DATA_WIDTH-1:0] flit_data_i,
    input  logic                  pop_i,
    output logic                  flit_valid_o,
    output logic [DATA_WIDTH-1:0] flit_data_o,
    output logic                  cc_inc_o,
    output logic [CNT_W-1:0]      count_o,
    output logic                  overflow_o
);

    logic [DATA_WIDTH-1:0] entry [0:DEPTH-1];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count;
    logic                  cc_inc_p0;
    logic                  overflow;

    logic                  not_empty;
    logic                  not_full;
    logic                  do_pop;
    logic                  do_push;

    // Pointers wrap at DEPTH-1 so a non-power-of-two DEPTH never indexes
    // past the end of the array.
    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            return '0;
        end
        return p + PTR_W'(1);
    endfunction

    assign not_empty = (count != '0);
    assign not_full  = (count != CNT_W'(DEPTH));
    assign do_pop    = pop_i & not_empty;
    // A pop on a full buffer frees a slot in the same cycle, so the push lands.
    assign do_push   = flit_valid_i & (not_full | do_pop);

    // Control state: pointers, occupancy, credit pulse, sticky overflow
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            cc_inc_p0 <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            cc_inc_p0 <= do_pop;
            if (do_push) begin
                wr_ptr <= ptr_next(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            if (do_push && !do_pop) begin
                count <= count + CNT_W'(1);
            end else if (do_pop && !do_push) begin
                count <= count - CNT_W'(1);
            end
            if (flit_valid_i && !do_push) begin
                overflow <= 1'b1;
            end
        end
    end

    // Storage array: data only, deliberately left out of reset
    always_ff @(posedge clk) begin
        if (do_push) begin
            entry[wr_ptr] <= flit_data_i;
        end
    end

    // Outputs come from registered state only; no push-to-head bypass.
    assign flit_valid_o = not_empty;
    assign flit_data_o  = not_empty ? entry[rd_ptr] : '0;
    assign cc_inc_o     = cc_inc_p0;
    assign count_o      = count;
    assign overflow_o   = overflow;

endmodule
